// File: rtl/spi_master_dc.sv
// SPI master (CPHA=0, CPOL param) with D/C line and burst chip-select hold; SPI_RX_EN adds miso/rx_data/rx_valid.
// Latency: accept cycle + 2*CLK_DIV*DATA_W SHIFT cycles + CLK_DIV HOLD cycles, done in the last HOLD cycle.
// Backpressure: tx_ready only in IDLE/WAIT; a word in flight is never cut short by tx_* inputs.
module spi_master_dc #(
  parameter int   DATA_W  = 8,
  parameter int   CLK_DIV = 1,
  parameter logic CPOL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_dc,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              dc,
  output logic              busy,
`ifdef SPI_RX_EN
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
`endif
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [BIT_W-1:0] BIT_LD = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LD = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]        state, state_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic              half, half_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic              last_q, last_n;
  logic              dc_n;
  logic              done_n;
  logic              accept;

  assign tx_ready = (state == IDLE) || (state == WAIT);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  // half=0 is the mosi-setup half of a bit, half=1 the half after the sampling edge
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    div_n   = div_cnt;
    half_n  = half;
    sreg_n  = sreg;
    last_n  = last_q;
    dc_n    = dc;
    case (state)
      IDLE, WAIT: begin
        if (accept) begin
          state_n = SHIFT;
          bit_n   = BIT_LD;
          div_n   = DIV_LD;
          half_n  = 1'b0;
          sreg_n  = tx_data;
          last_n  = tx_last;
          dc_n    = tx_dc;
        end
      end
      SHIFT: begin
        if (div_cnt != '0) begin
          div_n = div_cnt - DIV_W'(1);
        end else if (!half) begin
          half_n = 1'b1;
          div_n  = DIV_LD;
        end else if (bit_cnt != '0) begin
          half_n = 1'b0;
          div_n  = DIV_LD;
          bit_n  = bit_cnt - BIT_W'(1);
          sreg_n = sreg << 1;
        end else begin
          state_n = HOLD;
          half_n  = 1'b0;
          div_n   = DIV_LD;
          bit_n   = '0;
        end
      end
      HOLD: begin
        if (div_cnt != '0) begin
          div_n = div_cnt - DIV_W'(1);
        end else if (last_q) begin
          state_n = GAP;
          div_n   = DIV_LD;
          bit_n   = '0;
        end else begin
          state_n = WAIT;
          div_n   = '0;
          bit_n   = '0;
        end
      end
      GAP: begin
        if (div_cnt != '0) begin
          div_n = div_cnt - DIV_W'(1);
        end else begin
          state_n = IDLE;
          div_n   = '0;
          bit_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        div_n   = '0;
        bit_n   = '0;
        half_n  = 1'b0;
      end
    endcase
  end

  assign done_n = (state_n == HOLD) && (div_n == '0);

  // Outputs are registered from next-state values so pins change together with the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      half    <= 1'b0;
      sreg    <= '0;
      last_q  <= 1'b0;
      sclk    <= CPOL;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      dc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      div_cnt <= div_n;
      half    <= half_n;
      sreg    <= sreg_n;
      last_q  <= last_n;
      sclk    <= ((state_n == SHIFT) && half_n) ? ~CPOL : CPOL;
      if (state_n == SHIFT) mosi <= sreg_n[DATA_W-1];
      cs_n    <= !((state_n == SHIFT) || (state_n == HOLD) || (state_n == WAIT));
      dc      <= dc_n;
      done    <= done_n;
    end
  end

`ifdef SPI_RX_EN
  logic [DATA_W-1:0] rx_sreg, rx_sreg_n;
  logic              rx_sample;

  // First cycle of the second half is the cycle in which sclk shows its sampling edge
  assign rx_sample = (state == SHIFT) && half && (div_cnt == DIV_LD);
  assign rx_sreg_n = rx_sample ? {rx_sreg[DATA_W-2:0], miso} : rx_sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sreg  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sreg  <= rx_sreg_n;
      rx_valid <= done_n;
      if (done_n) rx_data <= rx_sreg_n;
    end
  end
`endif

endmodule
